// File: rtl/counter_monitor.sv
// counter_monitor: watches an external up-counter and its milestone/done flags,
// tracks milestones, and latches the first protocol violation it sees.
module counter_monitor #(
    parameter int unsigned LIMIT = 1_000_000,
    parameter int unsigned STEP  = 200_000,
    parameter int unsigned CW    = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] cnt_in,
    input  logic          milestone_in,
    input  logic          done_in,
    output logic [1:0]    state,
    output logic [3:0]    ms_count,
    output logic          err,
    output logic [2:0]    err_code,
    output logic [CW-1:0] err_at
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StTrack = 2'd1,
        StDone  = 2'd2,
        StFail  = 2'd3
    } state_e;

    localparam logic [CW-1:0] LimitC  = CW'(LIMIT);
    localparam logic [CW-1:0] StepC   = CW'(STEP);
    localparam logic [CW:0]   StepW   = (CW+1)'(STEP);
    // Saturation point for next_ms: one past the terminal count.
    localparam logic [CW:0]   LimitP1 = (CW+1)'(LIMIT) + (CW+1)'(1);

    state_e        r_state, w_state_nxt;
    logic [CW-1:0] r_prev, w_prev_nxt;
    logic [CW-1:0] r_next_ms, w_next_ms_nxt;
    logic [3:0]    r_ms_count, w_ms_count_nxt;
    logic          r_err, w_err_nxt;
    logic [2:0]    r_err_code, w_err_code_nxt;
    logic [CW-1:0] r_err_at, w_err_at_nxt;

    logic          w_ms_exp;
    logic          w_done_exp;
    logic          w_resync;
    logic [CW:0]   w_prev_inc;
    logic [CW:0]   w_next_sum;
    logic [CW-1:0] w_next_sat;
    logic          w_ms_match;
    logic [2:0]    w_chk_code;

    assign w_ms_exp   = (cnt_in != '0) && (cnt_in == r_next_ms);
    assign w_done_exp = (cnt_in == LimitC);
    // A zero count with done low means the observed counter was reset.
    assign w_resync   = (cnt_in == '0) && !done_in;
    // Extra bit keeps an all-ones prev from wrapping onto zero.
    assign w_prev_inc = {1'b0, r_prev} + (CW+1)'(1);
    assign w_next_sum = {1'b0, r_next_ms} + StepW;
    assign w_next_sat = (w_next_sum > LimitP1) ? LimitP1[CW-1:0] : w_next_sum[CW-1:0];
    assign w_ms_match = milestone_in && w_ms_exp;

    // Error cause for this sample; lowest code wins when several fire together.
    always_comb begin
        w_chk_code = 3'd0;
        if (!w_resync) begin
            if (r_state == StTrack) begin
                if ({1'b0, cnt_in} != w_prev_inc)  w_chk_code = 3'd1;
                else if (milestone_in != w_ms_exp) w_chk_code = 3'd2;
                else if (done_in != w_done_exp)    w_chk_code = 3'd3;
            end else if (r_state == StDone) begin
                if (milestone_in != w_ms_exp)               w_chk_code = 3'd2;
                else if ((cnt_in != LimitC) || !done_in)    w_chk_code = 3'd4;
            end
        end
    end

    // State register and all datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_prev     <= '0;
            r_next_ms  <= StepC;
            r_ms_count <= 4'd0;
            r_err      <= 1'b0;
            r_err_code <= 3'd0;
            r_err_at   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= w_prev_nxt;
            r_next_ms  <= w_next_ms_nxt;
            r_ms_count <= w_ms_count_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
            r_err_at   <= w_err_at_nxt;
        end
    end

    // Next-state decode; FAIL only leaves through reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (w_resync) w_state_nxt = StTrack;
            end
            StTrack: begin
                if (w_resync)                w_state_nxt = StTrack;
                else if (w_chk_code != 3'd0) w_state_nxt = StFail;
                else if (w_done_exp)         w_state_nxt = StDone;
            end
            StDone: begin
                if (w_resync)                w_state_nxt = StTrack;
                else if (w_chk_code != 3'd0) w_state_nxt = StFail;
            end
            default: w_state_nxt = r_state;
        endcase
    end

    // Datapath next values: resync, milestone tracking and first-error capture.
    always_comb begin
        w_prev_nxt     = r_prev;
        w_next_ms_nxt  = r_next_ms;
        w_ms_count_nxt = r_ms_count;
        w_err_nxt      = r_err;
        w_err_code_nxt = r_err_code;
        w_err_at_nxt   = r_err_at;
        if (r_state != StFail) begin
            if (w_resync) begin
                w_prev_nxt     = '0;
                w_next_ms_nxt  = StepC;
                w_ms_count_nxt = 4'd0;
            end else if (r_state != StIdle) begin
                if (w_ms_match) begin
                    w_ms_count_nxt = (r_ms_count == 4'd15) ? 4'd15 : r_ms_count + 4'd1;
                    w_next_ms_nxt  = w_next_sat;
                end
                if (w_chk_code != 3'd0) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = w_chk_code;
                    w_err_at_nxt   = cnt_in;
                end else if (r_state == StTrack) begin
                    w_prev_nxt = cnt_in;
                end
            end
        end
    end

    assign state    = r_state;
    assign ms_count = r_ms_count;
    assign err      = r_err;
    assign err_code = r_err_code;
    assign err_at   = r_err_at;

endmodule
